// File: rtl/riscv_mem_pkg.sv
// Shared types for the instruction-fetch / memory-access arbiter:
// the FSM state enum and the owner enum.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        IF = 1'b0,
        MA = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/riscv_arb_starve.sv
// Saturating count of consecutive IF arbitration losses; at_max tells the
// arbiter that IF must win the next contested arbitration.
module riscv_arb_starve #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CW'(MAX))) begin
            count <= count + CW'(1);
        end
    end

    assign at_max = (count == CW'(MAX));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and memory access (MA),
// one transaction at a time. Define RISCV_ARB_FAIR_EN for starvation-limited priority.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ma_req,
    input  logic            ma_we,
    input  logic [XLEN-1:0] ma_addr,
    input  logic [XLEN-1:0] ma_wdata,
    output logic            ma_gnt,
    output logic            ma_rvalid,
    output logic [XLEN-1:0] ma_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);
    arb_state_t      state, state_next;
    arb_owner_t      owner, owner_next;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic            we_q;
    logic            starve_at_max, ma_wins, if_wins, capture;

`ifdef RISCV_ARB_FAIR_EN
    logic starve_inc, starve_clr;

    assign starve_inc = capture && ma_wins && if_req;
    assign starve_clr = capture && if_wins;

    riscv_arb_starve #(.MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );
`else
    localparam int unused_starve_max = STARVE_MAX;
    assign starve_at_max = 1'b0;
`endif

    // MA has priority unless IF has already lost STARVE_MAX contested rounds.
    assign ma_wins = ma_req && !(if_req && starve_at_max);
    assign if_wins = if_req && !ma_wins;
    assign capture = (state == IDLE) && (ma_wins || if_wins);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= IF;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            if (capture) begin
                addr_q  <= ma_wins ? ma_addr : if_addr;
                wdata_q <= ma_wins ? ma_wdata : '0;
                we_q    <= ma_wins && ma_we;
            end
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        if_gnt     = 1'b0;
        ma_gnt     = 1'b0;
        if_rvalid  = 1'b0;
        ma_rvalid  = 1'b0;
        if_rdata   = '0;
        ma_rdata   = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = REQ;
                    owner_next = ma_wins ? MA : IF;
                    if_gnt     = if_wins;
                    ma_gnt     = ma_wins;
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ready) begin
                    state_next = we_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                    if (owner == MA) begin
                        ma_rvalid = 1'b1;
                        ma_rdata  = mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Outputs stay quiet for the whole reset cycle, not just after the edge.
        if (!rst) begin
            if_gnt    = 1'b0;
            ma_gnt    = 1'b0;
            if_rvalid = 1'b0;
            ma_rvalid = 1'b0;
            if_rdata  = '0;
            ma_rdata  = '0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_riscv_mem_arbiter;
    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 4;
`ifdef RISCV_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            if_req, ma_req, ma_we, mem_ready, mem_rvalid;
    logic [XLEN-1:0] if_addr, ma_addr, ma_wdata, mem_rdata;
    logic            if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_req, mem_we;
    logic [XLEN-1:0] if_rdata, ma_rdata, mem_addr, mem_wdata;
    logic [4*XLEN+5:0] all_outs;

    int total  = 0;
    int passed = 0;
    int if_losses = 0;

    riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign all_outs = {if_gnt, if_rvalid, if_rdata, ma_gnt, ma_rvalid, ma_rdata,
                       mem_req, mem_we, mem_addr, mem_wdata};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        ma_req = 1'b0; ma_we = 1'b0; ma_addr = '0; ma_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        if_losses = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if_req = 1'($urandom); if_addr = $urandom;
            ma_req = 1'($urandom); ma_we = 1'($urandom); ma_addr = $urandom; ma_wdata = $urandom;
            mem_ready = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            @(negedge clk);
            total++;
            if (all_outs !== '0) $display("[TB] FAIL reset_hold[%0d]: got %h expected 0", i, all_outs);
            else passed++;
            next_cycle();
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (all_outs !== '0) $display("[TB] FAIL reset_after: got %h expected 0", all_outs);
        else passed++;
        next_cycle();
    endtask

    task automatic test_if_read();
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        total++;
        if ({if_gnt, ma_gnt, mem_req} !== 3'b100) $display("[TB] FAIL if_read_gnt: got %b expected 100", {if_gnt, ma_gnt, mem_req});
        else passed++;
        next_cycle();
        if_req = 1'b0; if_addr = 32'hABC; mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_req, mem_we, if_gnt, ma_gnt} !== 4'b1000) $display("[TB] FAIL if_read_req: got %b expected 1000", {mem_req, mem_we, if_gnt, ma_gnt});
        else passed++;
        total++;
        if (mem_addr !== 32'h100) $display("[TB] FAIL if_read_addr: got %h expected 00000100", mem_addr);
        else passed++;
        next_cycle();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if ({if_rvalid, ma_rvalid, mem_req} !== 3'b100) $display("[TB] FAIL if_read_rvalid: got %b expected 100", {if_rvalid, ma_rvalid, mem_req});
        else passed++;
        total++;
        if ({if_rdata, ma_rdata} !== {32'hDEADBEEF, 32'h0}) $display("[TB] FAIL if_read_rdata: got %h/%h expected deadbeef/00000000", if_rdata, ma_rdata);
        else passed++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total++;
        if (all_outs !== '0) $display("[TB] FAIL if_read_idle: got %h expected 0", all_outs);
        else passed++;
        next_cycle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        if_req = 1'b1; if_addr = 32'h300;
        ma_req = 1'b1; ma_we = 1'b0; ma_addr = 32'h200;
        @(negedge clk);
        total++;
        if ({if_gnt, ma_gnt} !== 2'b01) $display("[TB] FAIL simul_gnt: got %b expected 01", {if_gnt, ma_gnt});
        else passed++;
        next_cycle();
        ma_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_req, if_gnt, mem_addr} !== {2'b10, 32'h200}) $display("[TB] FAIL simul_req: got %b/%h expected 10/00000200", {mem_req, if_gnt}, mem_addr);
        else passed++;
        next_cycle();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        total++;
        if ({ma_rvalid, if_rvalid, if_gnt, ma_rdata} !== {3'b100, 32'h5555AAAA}) $display("[TB] FAIL simul_ma_rvalid: got %b/%h expected 100/5555aaaa", {ma_rvalid, if_rvalid, if_gnt}, ma_rdata);
        else passed++;
        next_cycle();
        mem_rvalid = 1'b0;
        @(negedge clk);
        total++;
        if ({if_gnt, ma_gnt} !== 2'b10) $display("[TB] FAIL simul_if_gnt: got %b expected 10", {if_gnt, ma_gnt});
        else passed++;
        next_cycle();
        if_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h300}) $display("[TB] FAIL simul_if_addr: got %b/%h expected 1/00000300", mem_req, mem_addr);
        else passed++;
        next_cycle();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        total++;
        if ({if_rvalid, ma_rvalid, if_rdata} !== {2'b10, 32'h0BADF00D}) $display("[TB] FAIL simul_if_rvalid: got %b/%h expected 10/0badf00d", {if_rvalid, ma_rvalid}, if_rdata);
        else passed++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_ma_write();
        do_reset();
        ma_req = 1'b1; ma_we = 1'b1; ma_addr = 32'h40; ma_wdata = 32'h12345678;
        @(negedge clk);
        total++;
        if ({ma_gnt, if_gnt} !== 2'b10) $display("[TB] FAIL write_gnt: got %b expected 10", {ma_gnt, if_gnt});
        else passed++;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            ma_req = 1'b0; ma_we = 1'($urandom); ma_addr = $urandom; ma_wdata = $urandom;
            mem_ready = (i == 3); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            @(negedge clk);
            total++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, if_rvalid, ma_rvalid} !== {2'b11, 32'h40, 32'h12345678, 2'b00})
                $display("[TB] FAIL write_hold[%0d]: got %b%b %h %h rv=%b%b expected 11 00000040 12345678 rv=00", i, mem_req, mem_we, mem_addr, mem_wdata, if_rvalid, ma_rvalid);
            else passed++;
            next_cycle();
        end
        idle_inputs();
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF0000; if_req = 1'b1; if_addr = 32'h4;
        @(negedge clk);
        total++;
        if ({mem_req, if_rvalid, ma_rvalid, if_gnt, ma_gnt} !== 5'b00010) $display("[TB] FAIL write_done: got %b expected 00010", {mem_req, if_rvalid, ma_rvalid, if_gnt, ma_gnt});
        else passed++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        if_req = 1'b1; if_addr = 32'h80;
        next_cycle();
        if_req = 1'b0; mem_ready = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_req, if_rvalid, ma_rvalid} !== 3'b000) $display("[TB] FAIL wait_quiet: got %b expected 000", {mem_req, if_rvalid, ma_rvalid});
        else passed++;
        next_cycle();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
        @(negedge clk);
        total++;
        if (all_outs !== '0) $display("[TB] FAIL wait_reset_outs: got %h expected 0", all_outs);
        else passed++;
        next_cycle();
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        total++;
        if (all_outs !== '0) $display("[TB] FAIL wait_reset_stale_rvalid: got %h expected 0", all_outs);
        else passed++;
        next_cycle();
        mem_rvalid = 1'b0; ma_req = 1'b1; ma_addr = 32'h44;
        @(negedge clk);
        total++;
        if ({ma_gnt, if_gnt, mem_req} !== 3'b100) $display("[TB] FAIL wait_reset_idle: got %b expected 100", {ma_gnt, if_gnt, mem_req});
        else passed++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_priority();
        int ma_grants = 0;
        int exp_ma_grants = 0;
        logic exp_if;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            exp_if = FAIR && ((k % (STARVE_MAX + 1)) == STARVE_MAX);
            if (!exp_if) exp_ma_grants++;
            if_req = 1'b1; ma_req = 1'b1; ma_we = 1'b0;
            if_addr = $urandom; ma_addr = $urandom;
            @(negedge clk);
            total++;
            if ({if_gnt, ma_gnt} !== {exp_if, !exp_if}) $display("[TB] FAIL prio_gnt[%0d]: got %b expected %b", k, {if_gnt, ma_gnt}, {exp_if, !exp_if});
            else passed++;
            if (ma_gnt === 1'b1) ma_grants++;
            next_cycle();
            mem_ready = 1'b1;
            next_cycle();
            mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            total++;
            if ({if_rvalid, ma_rvalid} !== {exp_if, !exp_if}) $display("[TB] FAIL prio_rvalid[%0d]: got %b expected %b", k, {if_rvalid, ma_rvalid}, {exp_if, !exp_if});
            else passed++;
            next_cycle();
            mem_rvalid = 1'b0;
        end
        total++;
        if (ma_grants !== exp_ma_grants) $display("[TB] FAIL prio_ma_count: got %0d expected %0d", ma_grants, exp_ma_grants);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_random();
        logic ir, mr, win_ma, exp_we, last;
        logic [XLEN-1:0] exp_addr, exp_wdata, rd;
        int d;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            ir = 1'($urandom); mr = 1'($urandom);
            if_req = ir; ma_req = mr; if_addr = $urandom; ma_addr = $urandom;
            ma_we = 1'($urandom); ma_wdata = $urandom;
            mem_ready = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            // Model: MA beats IF unless IF has lost STARVE_MAX contested rounds.
            win_ma = mr && !(ir && FAIR && (if_losses >= STARVE_MAX));
            @(negedge clk);
            total++;
            if ({if_gnt, ma_gnt, if_rvalid, ma_rvalid, mem_req} !== {ir && !win_ma, win_ma, 3'b000})
                $display("[TB] FAIL rand_gnt[%0d]: got %b expected %b", t, {if_gnt, ma_gnt, if_rvalid, ma_rvalid, mem_req}, {ir && !win_ma, win_ma, 3'b000});
            else passed++;
            if (!ir && !mr) begin
                next_cycle();
                continue;
            end
            if (!win_ma) if_losses = 0;
            else if (ir && if_losses < STARVE_MAX) if_losses++;
            exp_addr  = win_ma ? ma_addr : if_addr;
            exp_we    = win_ma && ma_we;
            exp_wdata = ma_wdata;
            next_cycle();
            d = $urandom_range(0, 3);
            for (int i = 0; i <= d; i++) begin
                if_req = 1'($urandom); ma_req = 1'($urandom); ma_addr = $urandom; if_addr = $urandom;
                ma_wdata = $urandom; mem_rvalid = 1'($urandom); mem_ready = (i == d);
                @(negedge clk);
                total++;
                if ({mem_req, mem_we, mem_addr, if_gnt, ma_gnt, if_rvalid, ma_rvalid} !== {1'b1, exp_we, exp_addr, 4'b0000} ||
                    (exp_we && mem_wdata !== exp_wdata))
                    $display("[TB] FAIL rand_req[%0d]: got %b%b %h %h %b expected 1%b %h %h 0000", t, mem_req, mem_we, mem_addr, mem_wdata, {if_gnt, ma_gnt, if_rvalid, ma_rvalid}, exp_we, exp_addr, exp_wdata);
                else passed++;
                next_cycle();
            end
            if (exp_we) continue;
            d = $urandom_range(0, 3);
            for (int i = 0; i <= d; i++) begin
                last = (i == d);
                rd = $urandom;
                if_req = 1'($urandom); ma_req = 1'($urandom);
                mem_ready = 1'($urandom); mem_rvalid = last; mem_rdata = rd;
                @(negedge clk);
                total++;
                if ({mem_req, if_gnt, ma_gnt, if_rvalid, ma_rvalid} !== {3'b000, last && !win_ma, last && win_ma} ||
                    if_rdata !== ((last && !win_ma) ? rd : '0) || ma_rdata !== ((last && win_ma) ? rd : '0))
                    $display("[TB] FAIL rand_wait[%0d]: got %b %h/%h expected %b rdata %h owner_ma=%b", t, {mem_req, if_gnt, ma_gnt, if_rvalid, ma_rvalid}, if_rdata, ma_rdata, {3'b000, last && !win_ma, last && win_ma}, rd, win_ma);
                else passed++;
                next_cycle();
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_if_read();
        test_simultaneous();
        test_ma_write();
        test_reset_in_wait();
        test_priority();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
